rab_l2_inv_sweep: RTL and testbench

RAB_L2_INV_SWEEP -- requirements
Module: rab_l2_inv_sweep

---
 rtl/rab_l2_inv_pkg.sv | 18 +
 rtl/rab_l2_inv_match.sv | 23 ++
 rtl/rab_l2_inv_sweep.sv | 166 ++++++++++++++++
 tb/tb_rab_l2_inv_sweep.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rab_l2_inv_pkg.sv
// Shared definitions for the L2 TLB invalidation sweep: FSM states and VA-word field positions.
package rab_l2_inv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CMP,
    S_WRITE,
    S_DONE
  } inv_state_e;

  // VA RAM word layout
  localparam int unsigned VA_BIT_VALID = 0;
  localparam int unsigned VA_BIT_WE    = 1;
  localparam int unsigned VA_BIT_RE    = 2;
  localparam int unsigned VA_VPN_LSB   = 4;

endpackage

// File: rtl/rab_l2_inv_match.sv
// Combinational page/range overlap test: does a valid page intersect [addr_min, addr_max]?
module rab_l2_inv_match #(
  parameter int unsigned AW          = 32,
  parameter int unsigned PAGE_OFFSET = 12
) (
  input  logic                      valid,
  input  logic [AW-PAGE_OFFSET-1:0] vpn,
  input  logic [AW-1:0]             addr_min,
  input  logic [AW-1:0]             addr_max,
  output logic                      match
);

  logic [AW-1:0] page_lo;
  logic [AW-1:0] page_hi;

  // First and last byte of the page, compared unsigned against the inclusive range
  always_comb begin
    page_lo = {vpn, {PAGE_OFFSET{1'b0}}};
    page_hi = {vpn, {PAGE_OFFSET{1'b1}}};
    match   = valid && (page_lo <= addr_max) && (page_hi >= addr_min);
  end

endmodule

// File: rtl/rab_l2_inv_sweep.sv
// L2 TLB range invalidation: walks every VA-RAM word in ascending order and clears
// the valid bit of each entry whose page overlaps the requested address range.
module rab_l2_inv_sweep
  import rab_l2_inv_pkg::*;
#(
  parameter int unsigned AW            = 32,
  parameter int unsigned N_SETS        = 32,
  parameter int unsigned N_SET_ENTRIES = 32,
  parameter int unsigned PAGE_OFFSET   = 12,
  localparam int unsigned N            = N_SETS * N_SET_ENTRIES,
  localparam int unsigned IW           = $clog2(N)
) (
  input  logic          Clk_CI,
  input  logic          Rst_RBI,
  input  logic          Inv_Valid_SI,
  output logic          Inv_Ready_SO,
  input  logic [AW-1:0] Inv_AddrMin_DI,
  input  logic [AW-1:0] Inv_AddrMax_DI,
  output logic          Inv_Done_SO,
  output logic          Busy_SO,
  output logic [IW:0]   Inv_Count_DO,
  output logic          Ram_Req_SO,
  input  logic          Ram_Gnt_SI,
  output logic          Ram_We_SO,
  output logic [IW-1:0] Ram_Addr_DO,
  output logic [AW-1:0] Ram_Wdata_DO,
  input  logic [AW-1:0] Ram_Rdata_DI,
  input  logic          Cfg_Wr_SI,
  input  logic [IW-1:0] Cfg_WrAddr_DI
);

  localparam int unsigned   VPN_W    = AW - PAGE_OFFSET;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  inv_state_e    state_q;
  logic [AW-1:0] min_q;
  logic [AW-1:0] max_q;
  logic [IW-1:0] idx_q;
  logic [IW:0]   cnt_q;
  logic [IW:0]   cnt_out_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic          req_q;
  logic          we_q;
  logic [AW-1:0] wdata_q;
  logic          hit;
  logic          cfg_hit;

  rab_l2_inv_match #(
    .AW          (AW),
    .PAGE_OFFSET (PAGE_OFFSET)
  ) u_match (
    .valid    (Ram_Rdata_DI[VA_BIT_VALID]),
    .vpn      (Ram_Rdata_DI[VA_VPN_LSB +: VPN_W]),
    .addr_min (min_q),
    .addr_max (max_q),
    .match    (hit)
  );

  // A config-port write to the entry under inspection makes the sampled word stale
  assign cfg_hit = Cfg_Wr_SI && (Cfg_WrAddr_DI == idx_q);

  // Sweep FSM with registered handshake, RAM and status outputs
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q   <= S_IDLE;
      min_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      cnt_out_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (Inv_Valid_SI && ready_q) begin
            min_q   <= Inv_AddrMin_DI;
            max_q   <= Inv_AddrMax_DI;
            idx_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            we_q    <= 1'b0;
            // an empty range never touches the RAM
            req_q   <= (Inv_AddrMin_DI <= Inv_AddrMax_DI);
            state_q <= S_READ;
          end
        end
        S_READ: begin
          if (min_q > max_q) begin
            req_q     <= 1'b0;
            done_q    <= 1'b1;
            cnt_out_q <= cnt_q;
            state_q   <= S_DONE;
          end else if (Ram_Gnt_SI) begin
            req_q   <= 1'b0;
            state_q <= S_CMP;
          end
        end
        S_CMP: begin
          if (cfg_hit) begin
            req_q   <= 1'b1;
            state_q <= S_READ;
          end else if (hit) begin
            req_q                 <= 1'b1;
            we_q                  <= 1'b1;
            wdata_q               <= Ram_Rdata_DI;
            wdata_q[VA_BIT_VALID] <= 1'b0;
            state_q               <= S_WRITE;
          end else if (idx_q == IDX_LAST) begin
            done_q    <= 1'b1;
            cnt_out_q <= cnt_q;
            state_q   <= S_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            req_q   <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_WRITE: begin
          if (Ram_Gnt_SI) begin
            cnt_q <= cnt_q + 1'b1;
            we_q  <= 1'b0;
            if (idx_q == IDX_LAST) begin
              req_q     <= 1'b0;
              done_q    <= 1'b1;
              cnt_out_q <= cnt_q + 1'b1;
              state_q   <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_READ;
            end
          end else if (cfg_hit) begin
            // request stays up, now as a re-read of the same entry
            we_q    <= 1'b0;
            state_q <= S_READ;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Inv_Ready_SO = ready_q;
  assign Inv_Done_SO  = done_q;
  assign Busy_SO      = busy_q;
  assign Inv_Count_DO = cnt_out_q;
  assign Ram_Req_SO   = req_q;
  assign Ram_We_SO    = we_q;
  assign Ram_Addr_DO  = idx_q;
  assign Ram_Wdata_DO = wdata_q;

endmodule

// File: tb/tb_rab_l2_inv_sweep.sv
// Self-checking bench for rab_l2_inv_sweep with a 16-entry VA RAM model.
module tb_rab_l2_inv_sweep;

  localparam int unsigned N  = 16;
  localparam int unsigned IW = 4;

  logic          Clk_CI = 1'b0;
  logic          Rst_RBI = 1'b1;
  logic          Inv_Valid_SI = 1'b0;
  logic          Inv_Ready_SO;
  logic [31:0]   Inv_AddrMin_DI = '0;
  logic [31:0]   Inv_AddrMax_DI = '0;
  logic          Inv_Done_SO;
  logic          Busy_SO;
  logic [IW:0]   Inv_Count_DO;
  logic          Ram_Req_SO;
  logic          Ram_Gnt_SI = 1'b1;
  logic          Ram_We_SO;
  logic [IW-1:0] Ram_Addr_DO;
  logic [31:0]   Ram_Wdata_DO;
  logic [31:0]   Ram_Rdata_DI = '0;
  logic          Cfg_Wr_SI = 1'b0;
  logic [IW-1:0] Cfg_WrAddr_DI = '0;
  logic [31:0]   cfg_wdata = '0;

  logic [31:0]   mem [N];
  logic [31:0]   exp_mem [N];
  int            exp_cnt;
  int            exp_hits [$];
  logic [4:0]    ev_q [$];

  int            gnt_mode = 0;
  int            stall_left = 0;
  bit            stall_armed = 0;
  logic [IW-1:0] stall_addr = '0;
  int            done_cnt = 0;
  int            req_cycles = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  rab_l2_inv_sweep #(
    .AW            (32),
    .N_SETS        (4),
    .N_SET_ENTRIES (4),
    .PAGE_OFFSET   (12)
  ) dut (
    .Clk_CI         (Clk_CI),
    .Rst_RBI        (Rst_RBI),
    .Inv_Valid_SI   (Inv_Valid_SI),
    .Inv_Ready_SO   (Inv_Ready_SO),
    .Inv_AddrMin_DI (Inv_AddrMin_DI),
    .Inv_AddrMax_DI (Inv_AddrMax_DI),
    .Inv_Done_SO    (Inv_Done_SO),
    .Busy_SO        (Busy_SO),
    .Inv_Count_DO   (Inv_Count_DO),
    .Ram_Req_SO     (Ram_Req_SO),
    .Ram_Gnt_SI     (Ram_Gnt_SI),
    .Ram_We_SO      (Ram_We_SO),
    .Ram_Addr_DO    (Ram_Addr_DO),
    .Ram_Wdata_DO   (Ram_Wdata_DO),
    .Ram_Rdata_DI   (Ram_Rdata_DI),
    .Cfg_Wr_SI      (Cfg_Wr_SI),
    .Cfg_WrAddr_DI  (Cfg_WrAddr_DI)
  );

  always #5 Clk_CI = ~Clk_CI;

  // RAM model: read data valid only in the cycle after a granted read, junk otherwise
  always @(posedge Clk_CI) begin
    Ram_Rdata_DI <= $urandom;
    if (Ram_Req_SO && Ram_Gnt_SI) begin
      ev_q.push_back({Ram_We_SO, Ram_Addr_DO});
      if (Ram_We_SO) mem[Ram_Addr_DO] = Ram_Wdata_DO;
      else           Ram_Rdata_DI <= mem[Ram_Addr_DO];
    end
    if (Cfg_Wr_SI) mem[Cfg_WrAddr_DI] = cfg_wdata;
  end

  // Grant driver: 0 always grant, 1 random grant, 2 stall one read of stall_addr for 5 cycles
  always @(negedge Clk_CI) begin
    if (gnt_mode == 1) begin
      Ram_Gnt_SI = 1'($urandom_range(0, 1));
    end else if (gnt_mode == 2) begin
      if (stall_left > 0) begin
        Ram_Gnt_SI = 1'b0;
        stall_left--;
      end else if (stall_armed && Ram_Req_SO && !Ram_We_SO && Ram_Addr_DO == stall_addr) begin
        stall_armed = 0;
        stall_left  = 4;
        Ram_Gnt_SI  = 1'b0;
      end else begin
        Ram_Gnt_SI = 1'b1;
      end
    end else begin
      Ram_Gnt_SI = 1'b1;
    end
  end

  // Activity counters
  always @(negedge Clk_CI) begin
    if (Inv_Done_SO) done_cnt++;
    if (Ram_Req_SO)  req_cycles++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  // Reference: a valid page [vpn*4096, vpn*4096+4095] is cleared if it intersects [mn, mx]
  function automatic bit page_hit(logic [31:0] w, logic [31:0] mn, logic [31:0] mx);
    longint unsigned lo, hi, lmn, lmx;
    lo  = longint'(w[23:4]) * 64'd4096;
    hi  = lo + 64'd4095;
    lmn = {32'd0, mn};
    lmx = {32'd0, mx};
    return (w[0] == 1'b1) && (lo <= lmx) && (hi >= lmn);
  endfunction

  task automatic model_sweep(input logic [31:0] mn, input logic [31:0] mx);
    exp_cnt = 0;
    exp_hits.delete();
    for (int i = 0; i < N; i++) begin
      exp_mem[i] = mem[i];
      if (mn <= mx && page_hit(mem[i], mn, mx)) begin
        exp_mem[i][0] = 1'b0;
        exp_cnt++;
        exp_hits.push_back(i);
      end
    end
  endtask

  task automatic fill_linear();
    for (int i = 0; i < N; i++) mem[i] = (32'(i) << 4) | 32'd1;
  endtask

  // Handshake one request and wait for its Done pulse; lat counts cycles after the handshake cycle
  task automatic run_sweep(input logic [31:0] mn, input logic [31:0] mx,
                           output int lat, output logic [IW:0] cnt, output bit tout);
    int t;
    tout = 0;
    lat  = 0;
    cnt  = '0;
    @(negedge Clk_CI);
    done_cnt = 0;
    req_cycles = 0;
    Inv_AddrMin_DI = mn;
    Inv_AddrMax_DI = mx;
    Inv_Valid_SI = 1'b1;
    t = 0;
    while (Inv_Ready_SO !== 1'b1 && t < 200) begin @(negedge Clk_CI); t++; end
    if (Inv_Ready_SO !== 1'b1) tout = 1;
    @(negedge Clk_CI);
    Inv_Valid_SI = 1'b0;
    lat = 1;
    while (Inv_Done_SO !== 1'b1 && lat < 4000) begin @(negedge Clk_CI); lat++; end
    if (Inv_Done_SO !== 1'b1) tout = 1;
    cnt = Inv_Count_DO;
    repeat (3) @(negedge Clk_CI);
  endtask

  task automatic test_reset();
    Rst_RBI = 1'b1;
    #2;
    Rst_RBI = 1'b0;
    repeat (3) @(negedge Clk_CI);
    n_checks++;
    if ({Inv_Ready_SO, Busy_SO, Inv_Done_SO, Ram_Req_SO, Ram_We_SO} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy/busy/done/req/we=%b exp=00000",
               {Inv_Ready_SO, Busy_SO, Inv_Done_SO, Ram_Req_SO, Ram_We_SO});
    end
    n_checks++;
    if (Inv_Count_DO !== '0) begin
      n_fail++;
      $display("FAIL reset_count got=%0d exp=0", Inv_Count_DO);
    end
    Rst_RBI = 1'b1;
    @(negedge Clk_CI);
    n_checks++;
    if (Inv_Ready_SO !== 1'b1 || Busy_SO !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_rise got rdy=%b busy=%b exp rdy=1 busy=0", Inv_Ready_SO, Busy_SO);
    end
  endtask

  task automatic test_basic();
    int lat; logic [IW:0] cnt; bit tout; int wr [$]; bit ord_ok;
    gnt_mode = 0;
    fill_linear();
    model_sweep(32'h3000, 32'h5FFF);
    ev_q.delete();
    run_sweep(32'h3000, 32'h5FFF, lat, cnt, tout);
    n_checks++;
    if (tout) begin n_fail++; $display("FAIL basic_timeout got=timeout exp=done"); end
    n_checks++;
    if (cnt !== 5'(exp_cnt)) begin n_fail++; $display("FAIL basic_count got=%0d exp=%0d", cnt, exp_cnt); end
    n_checks++;
    if (lat != 36) begin n_fail++; $display("FAIL basic_latency got=%0d exp=36", lat); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL basic_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]);
      end
    end
    foreach (ev_q[k]) if (ev_q[k][4]) wr.push_back(int'(ev_q[k][3:0]));
    ord_ok = (wr.size() == exp_hits.size());
    if (ord_ok) foreach (wr[k]) if (wr[k] != exp_hits[k]) ord_ok = 0;
    n_checks++;
    if (!ord_ok) begin
      n_fail++;
      $display("FAIL basic_write_order got=%0d writes exp=%0d writes in ascending hit order", wr.size(), exp_hits.size());
    end
  endtask

  task automatic test_partial();
    int lat; logic [IW:0] cnt; bit tout;
    gnt_mode = 0;
    fill_linear();
    model_sweep(32'h3FFF, 32'h4000);
    run_sweep(32'h3FFF, 32'h4000, lat, cnt, tout);
    n_checks++;
    if (tout || cnt !== 5'(exp_cnt)) begin
      n_fail++;
      $display("FAIL partial_count got=%0d timeout=%0d exp=%0d", cnt, tout, exp_cnt);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL partial_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_empty_range();
    int lat; logic [IW:0] cnt; bit tout;
    gnt_mode = 0;
    fill_linear();
    ev_q.delete();
    run_sweep(32'h5000, 32'h4000, lat, cnt, tout);
    n_checks++;
    if (tout || lat != 2) begin n_fail++; $display("FAIL empty_done_latency got=%0d exp=2", lat); end
    n_checks++;
    if (req_cycles != 0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL empty_ram_requests got=%0d exp=0", req_cycles);
    end
    n_checks++;
    if (cnt !== '0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL empty_count got=%0d pulses=%0d exp=0 pulses=1", cnt, done_cnt);
    end
  endtask

  task automatic test_stall();
    int lat; logic [IW:0] cnt; bit tout; int t;
    gnt_mode = 2;
    stall_addr = 4'd2;
    stall_armed = 1;
    fill_linear();
    model_sweep(32'h3000, 32'h5FFF);
    fork
      run_sweep(32'h3000, 32'h5FFF, lat, cnt, tout);
      begin
        t = 0;
        while (!(Ram_Req_SO && !Ram_We_SO && Ram_Addr_DO == 4'd2) && t < 300) begin
          @(negedge Clk_CI);
          t++;
        end
        for (int k = 1; k <= 5; k++) begin
          @(negedge Clk_CI);
          n_checks++;
          if (Ram_Req_SO !== 1'b1 || Ram_We_SO !== 1'b0 || Ram_Addr_DO !== 4'd2) begin
            n_fail++;
            $display("FAIL stall_hold cycle=%0d got req=%b we=%b addr=%0d exp req=1 we=0 addr=2",
                     k, Ram_Req_SO, Ram_We_SO, Ram_Addr_DO);
          end
        end
      end
    join
    gnt_mode = 0;
    n_checks++;
    if (tout || lat != 41 || stall_armed) begin
      n_fail++;
      $display("FAIL stall_latency got=%0d stall_pending=%0d exp=41", lat, stall_armed);
    end
    n_checks++;
    if (cnt !== 5'(exp_cnt)) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", cnt, exp_cnt); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL stall_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_cfg_abort();
    int lat; logic [IW:0] cnt; bit tout; int t; logic [31:0] saved; logic [2:0] seq; int n4;
    gnt_mode = 0;
    fill_linear();
    saved = mem[4];
    mem[4] = 32'h43;            // value the config port will write: valid + write-enable
    model_sweep(32'h3000, 32'h5FFF);
    mem[4] = saved;
    ev_q.delete();
    fork
      run_sweep(32'h3000, 32'h5FFF, lat, cnt, tout);
      begin
        t = 0;
        while (!(Ram_Req_SO && !Ram_We_SO && Ram_Addr_DO == 4'd4) && t < 300) begin
          @(negedge Clk_CI);
          t++;
        end
        @(negedge Clk_CI);
        Cfg_Wr_SI = 1'b1;
        Cfg_WrAddr_DI = 4'd4;
        cfg_wdata = 32'h43;
        @(negedge Clk_CI);
        Cfg_Wr_SI = 1'b0;
      end
    join
    seq = '0;
    n4 = 0;
    foreach (ev_q[k]) if (ev_q[k][3:0] == 4'd4) begin
      if (n4 < 3) seq[2 - n4] = ev_q[k][4];
      n4++;
    end
    n_checks++;
    if (n4 != 3 || seq !== 3'b001) begin
      n_fail++;
      $display("FAIL cfg_abort_sequence got=%0d accesses pattern=%b exp=3 accesses pattern=001", n4, seq);
    end
    n_checks++;
    if (tout || lat != 38) begin n_fail++; $display("FAIL cfg_abort_latency got=%0d exp=38", lat); end
    n_checks++;
    if (cnt !== 5'(exp_cnt)) begin n_fail++; $display("FAIL cfg_abort_count got=%0d exp=%0d", cnt, exp_cnt); end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL cfg_abort_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_reset_midsweep();
    int lat; logic [IW:0] cnt; bit tout; int t; bit found; int n_ev;
    gnt_mode = 0;
    fill_linear();
    ev_q.delete();
    @(negedge Clk_CI);
    Inv_AddrMin_DI = 32'h3000;
    Inv_AddrMax_DI = 32'h5FFF;
    Inv_Valid_SI = 1'b1;
    t = 0;
    while (Inv_Ready_SO !== 1'b1 && t < 200) begin @(negedge Clk_CI); t++; end
    @(negedge Clk_CI);
    Inv_Valid_SI = 1'b0;
    found = 0;
    t = 0;
    while (!found && t < 200) begin
      @(negedge Clk_CI);
      t++;
      foreach (ev_q[k]) if (ev_q[k] == 5'h13) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midreset_entry3_write got=none exp=write to 3"); end
    Rst_RBI = 1'b0;
    #1;
    n_checks++;
    if ({Busy_SO, Ram_Req_SO, Ram_We_SO, Inv_Ready_SO, Inv_Done_SO} !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs got busy/req/we/rdy/done=%b exp=00000",
               {Busy_SO, Ram_Req_SO, Ram_We_SO, Inv_Ready_SO, Inv_Done_SO});
    end
    n_ev = ev_q.size();
    repeat (3) @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    repeat (20) @(negedge Clk_CI);
    n_checks++;
    if (ev_q.size() != n_ev || Busy_SO !== 1'b0 || Inv_Count_DO !== '0) begin
      n_fail++;
      $display("FAIL midreset_quiet got accesses=%0d busy=%b count=%0d exp accesses=0 busy=0 count=0",
               ev_q.size() - n_ev, Busy_SO, Inv_Count_DO);
    end
    // only entry 3 was cleared before the reset
    fill_linear();
    mem[3][0] = 1'b0;
    for (int i = 0; i < N; i++) exp_mem[i] = mem[i];
    model_sweep(32'h4000, 32'h4FFF);
    run_sweep(32'h4000, 32'h4FFF, lat, cnt, tout);
    n_checks++;
    if (tout || cnt !== 5'(exp_cnt) || done_cnt != 1) begin
      n_fail++;
      $display("FAIL midreset_new_sweep got count=%0d pulses=%0d exp count=%0d pulses=1", cnt, done_cnt, exp_cnt);
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++;
        $display("FAIL midreset_mem[%0d] got=%h exp=%h", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [IW:0] cnt; bit tout; logic [31:0] mn, mx, w;
    gnt_mode = 1;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++) begin
        w = $urandom;
        w[23:4] = 20'($urandom_range(0, 24));
        mem[i] = w;
      end
      if (it == 0) begin
        mn = 32'h0;
        mx = 32'hFFFF_FFFF;
      end else begin
        mn = 32'($urandom_range(0, 26 * 4096));
        if ($urandom_range(0, 4) == 0) mx = mn - 32'($urandom_range(1, 4096));
        else                           mx = mn + 32'($urandom_range(0, 8 * 4096));
      end
      model_sweep(mn, mx);
      run_sweep(mn, mx, lat, cnt, tout);
      n_checks++;
      if (tout || cnt !== 5'(exp_cnt) || done_cnt != 1) begin
        n_fail++;
        $display("FAIL random_count it=%0d min=%h max=%h got=%0d pulses=%0d exp=%0d pulses=1",
                 it, mn, mx, cnt, done_cnt, exp_cnt);
      end
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (mem[i] !== exp_mem[i]) begin
          n_fail++;
          $display("FAIL random_mem it=%0d idx=%0d got=%h exp=%h", it, i, mem[i], exp_mem[i]);
        end
      end
    end
    gnt_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_partial();
    test_empty_range();
    test_stall();
    test_cfg_abort();
    test_reset_midsweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
